// File: rtl/pipe_delay_line.sv
// pipe_delay_line: parametrised register chain for aligning operand and control
// paths. The latency is selectable at run time, from 0 (combinational bypass)
// up to DEPTH enabled edges. A valid bit travels alongside each data stage.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset, clears all state
//   ce        clock enable; the chain shifts only when high
//   clr       synchronous flush; has priority over ce
//   lat       selected latency 0..DEPTH; larger values clamp to DEPTH
//   din       data in
//   din_vld   data-in valid qualifier
//   dout      delayed data (tap selected combinationally by lat)
//   dout_vld  delayed valid
//   primed    selected tap holds data that entered after the last rst/clr/lat change
module pipe_delay_line #(
   parameter int unsigned WIDTH = 18,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             clr,
   input  logic [LW-1:0]    lat,
   input  logic [WIDTH-1:0] din,
   input  logic             din_vld,
   output logic [WIDTH-1:0] dout,
   output logic             dout_vld,
   output logic             primed
);

   localparam logic [LW-1:0] DepthL = LW'(DEPTH);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [LW-1:0]    fill_q;
   logic [LW-1:0]    lat_q;
   // Low only for the first edge after reset, so that edge just samples lat into
   // lat_q instead of counting as a latency change.
   logic             lat_init_q;
   logic [LW-1:0]    lat_c;
   logic             lat_chg;

   assign lat_c   = (lat > DepthL) ? DepthL : lat;
   assign lat_chg = lat_init_q && (lat_c != lat_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_q[k] <= '0;
         end
         vld_q      <= '0;
         fill_q     <= '0;
         lat_q      <= '0;
         lat_init_q <= 1'b0;
      end else begin
         lat_q      <= lat_c;
         lat_init_q <= 1'b1;
         if (clr) begin
            for (int k = 0; k < DEPTH; k++) begin
               stage_q[k] <= '0;
            end
            vld_q  <= '0;
            fill_q <= '0;
         end else begin
            if (ce) begin
               stage_q[0] <= din;
               vld_q[0]   <= din_vld;
               for (int k = 1; k < DEPTH; k++) begin
                  stage_q[k] <= stage_q[k-1];
                  vld_q[k]   <= vld_q[k-1];
               end
            end
            // A latency change restarts priming even while stalled.
            if (lat_chg) begin
               fill_q <= '0;
            end else if (ce && (fill_q != DepthL)) begin
               fill_q <= fill_q + LW'(1);
            end
         end
      end
   end

   // Tap select; lat_c == 0 leaves the bypass defaults in place.
   always_comb begin
      dout     = din;
      dout_vld = din_vld;
      for (int k = 0; k < DEPTH; k++) begin
         if (lat_c == LW'(k + 1)) begin
            dout     = stage_q[k];
            dout_vld = vld_q[k];
         end
      end
   end

   assign primed = (fill_q >= lat_c);

endmodule

// File: tb/tb_pipe_delay_line.sv
module tb_pipe_delay_line;

   localparam int unsigned WIDTH = 18;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             ce;
   logic             clr;
   logic [LW-1:0]    lat;
   logic [WIDTH-1:0] din;
   logic             din_vld;
   logic [WIDTH-1:0] dout;
   logic             dout_vld;
   logic             primed;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_delay_line #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .clr      (clr),
      .lat      (lat),
      .din      (din),
      .din_vld  (din_vld),
      .dout     (dout),
      .dout_vld (dout_vld),
      .primed   (primed)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [31:0] d, input logic v, input logic p);
      chk({tag, ".dout"}, 32'(dout), d);
      chk({tag, ".vld"}, 32'(dout_vld), 32'(v));
      chk({tag, ".primed"}, 32'(primed), 32'(p));
   endtask

   // Stall table: ce, din, expected dout/vld/primed before the edge (lat=2).
   logic        st_ce  [8] = '{1, 0, 1, 0, 0, 1, 1, 1};
   logic [17:0] st_din [8] = '{10, 99, 11, 12, 12, 12, 13, 14};
   logic [17:0] st_exp [8] = '{0, 0, 0, 10, 10, 10, 11, 12};
   logic        st_v   [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
   logic        st_p   [8] = '{0, 0, 0, 1, 1, 1, 1, 1};

   initial begin
      rst = 1'b1; ce = 1'b0; clr = 1'b0; lat = 3'd3; din = '0; din_vld = 1'b0;

      // Reset state
      @(negedge clk);
      chk_out("reset", 0, 0, 0);
      lat = 3'd0; din = 18'h0abcd; din_vld = 1'b1;
      #1;
      chk("reset_bypass.dout", 32'(dout), 32'h0abcd);
      lat = 3'd3;
      step();
      step();
      rst = 1'b0;

      // Latency 3 stream
      ce = 1'b1; din_vld = 1'b1;
      for (int i = 0; i < 6; i++) begin
         din = 18'(i + 1);
         @(negedge clk);
         chk_out($sformatf("lat3[%0d]", i), (i >= 3) ? 32'(i - 2) : 0, i >= 3, i >= 3);
         step();
      end

      // Flush together with a latency change, then the stall sequence at lat=2
      clr = 1'b1; lat = 3'd2;
      step();
      clr = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ce = st_ce[i]; din = st_din[i];
         @(negedge clk);
         chk_out($sformatf("stall[%0d]", i), 32'(st_exp[i]), st_v[i], st_p[i]);
         step();
      end

      // Fill at lat=4 with 0x155, then flush with ce high
      ce = 1'b1; lat = 3'd4; din = 18'h155; din_vld = 1'b1;
      for (int i = 0; i < 6; i++) step();
      @(negedge clk);
      chk_out("full", 32'h155, 1, 1);
      step();
      clr = 1'b1; din = 18'h2aa;
      @(negedge clk);
      chk_out("pre_clr", 32'h155, 1, 1);
      step();
      clr = 1'b0; din = 18'h155;
      @(negedge clk);
      chk_out("post_clr", 0, 0, 0);
      for (int n = 1; n <= 4; n++) begin
         step();
         @(negedge clk);
         chk_out($sformatf("refill[%0d]", n), (n >= 4) ? 32'h155 : 0, n >= 4, n >= 4);
      end
      step();

      // lat=7 clamps to 4: no latency change, same tap
      lat = 3'd7;
      for (int i = 0; i < 6; i++) begin
         din = 18'(32'h100 + i);
         @(negedge clk);
         chk_out($sformatf("clamp[%0d]", i), (i >= 4) ? 32'h100 + 32'(i - 4) : 32'h155, 1, 1);
         step();
      end

      // Switch 4 -> 1 mid-stream
      lat = 3'd1; din = 18'h200;
      @(negedge clk);
      chk_out("chg_pre", 32'h105, 1, 1);
      step();
      din = 18'h201;
      @(negedge clk);
      chk_out("chg_edge", 32'h200, 1, 0);
      step();
      din = 18'h202;
      @(negedge clk);
      chk_out("chg_after", 32'h201, 1, 1);
      step();

      // Asynchronous reset between edges
      lat = 3'd2; din = 18'h300;
      step();
      @(negedge clk);
      chk("pre_rst.vld", 32'(dout_vld), 1);
      #2;
      rst = 1'b1;
      #1;
      chk_out("rst_async", 0, 0, 0);
      step();
      chk_out("rst_held", 0, 0, 0);

      // Bypass
      lat = 3'd0; din = 18'h3ffff; din_vld = 1'b1;
      #1;
      chk("rst_lat0.dout", 32'(dout), 32'h3ffff);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk_out("bypass", 32'h3ffff, 1, 1);
      din = 18'h12345; din_vld = 1'b0;
      #1;
      chk_out("bypass_nv", 32'h12345, 0, 1);
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
